// File: rtl/score_cell_if.sv
// Handshake/bus bundle between the NW score-cell engine and its environment
// (score RAM, sequence RAMs, writer).
interface score_cell_if #(
  parameter int N       = 5,
  parameter int BitAddr = $clog2(N),
  parameter int ADDR_W  = $clog2((N+1)*(N+1))
);
  logic                    start;
  logic [1:0]              char_a;
  logic [1:0]              char_b;
  logic signed [8:0]       rd_data;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [BitAddr:0]        i;
  logic [BitAddr:0]        j;
  logic signed [8:0]       max;
  logic [1:0]              dir;
  logic                    en_ins;
  logic                    hit;
  logic                    busy;

  modport master (
    output start, char_a, char_b, rd_data,
    input  rd_en, rd_addr, i, j, max, dir, en_ins, hit, busy
  );

  modport slave (
    input  start, char_a, char_b, rd_data,
    output rd_en, rd_addr, i, j, max, dir, en_ins, hit, busy
  );
endinterface

// File: rtl/score_cell_engine.sv
// Row-major Needleman-Wunsch score-matrix fill, one cell every 5 cycles:
// read diag/up/left, pick the saturated max, hand it to the writer.
module score_cell_engine #(
  parameter int               N        = 5,
  parameter int               BitAddr  = $clog2(N),
  parameter int               ADDR_W   = $clog2((N+1)*(N+1)),
  parameter logic signed [8:0] MATCH    = 9'sd1,
  parameter logic signed [8:0] MISMATCH = -9'sd1,
  parameter logic signed [8:0] GAP      = -9'sd2
) (
  input logic         clk,
  input logic         rst,
  score_cell_if.slave bus
);
  localparam int            IW   = BitAddr + 1;
  localparam logic [IW-1:0] LAST = IW'(N);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [2:0] {IDLE, RD_DIAG, RD_UP, RD_LEFT, CALC, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]     i_q, j_q;
  logic signed [8:0] d_diag, d_up, max_q, max_nxt;
  logic signed [8:0] c_diag, c_up, c_left;
  logic [1:0]        dir_q, dir_nxt;

  function automatic logic signed [8:0] sat_add(input logic signed [8:0] a,
                                                input logic signed [8:0] b);
    logic signed [9:0] s;
    s = {a[8], a} + {b[8], b};
    if (s > 10'sd255)       return 9'sd255;
    else if (s < -10'sd256) return -9'sd256;
    else                    return s[8:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IW-1:0] r,
                                                input logic [IW-1:0] c);
    return ADDR_W'(int'(r) * (N + 1) + int'(c));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    case (state)
      IDLE:    if (bus.start) state_nxt = RD_DIAG;
      RD_DIAG: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr_of(i_q - ONE, j_q - ONE);
        state_nxt   = RD_UP;
      end
      RD_UP: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr_of(i_q - ONE, j_q);
        state_nxt   = RD_LEFT;
      end
      RD_LEFT: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr_of(i_q, j_q - ONE);
        state_nxt   = CALC;
      end
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = (i_q == LAST && j_q == LAST) ? DONE : RD_DIAG;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In CALC the left neighbour is still on rd_data, so it feeds the compare directly.
  always_comb begin
    c_diag = sat_add(d_diag, (bus.char_a == bus.char_b) ? MATCH : MISMATCH);
    c_up   = sat_add(d_up, GAP);
    c_left = sat_add(bus.rd_data, GAP);
    if (c_diag >= c_up && c_diag >= c_left) begin
      max_nxt = c_diag;
      dir_nxt = 2'b01;
    end else if (c_up >= c_left) begin
      max_nxt = c_up;
      dir_nxt = 2'b10;
    end else begin
      max_nxt = c_left;
      dir_nxt = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= ONE;
      j_q    <= ONE;
      d_diag <= '0;
      d_up   <= '0;
      max_q  <= '0;
      dir_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          i_q <= ONE;
          j_q <= ONE;
        end
        RD_UP:   d_diag <= bus.rd_data;
        RD_LEFT: d_up   <= bus.rd_data;
        CALC: begin
          max_q <= max_nxt;
          dir_q <= dir_nxt;
        end
        // Last cell leaves i/j parked at (N,N) for the writer and DONE.
        WRITE: begin
          if (j_q != LAST) begin
            j_q <= j_q + ONE;
          end else if (i_q != LAST) begin
            j_q <= ONE;
            i_q <= i_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i      = i_q;
  assign bus.j      = j_q;
  assign bus.max    = max_q;
  assign bus.dir    = dir_q;
  assign bus.en_ins = (state == WRITE);
  assign bus.hit    = (state == DONE);
  assign bus.busy   = (state != IDLE);
endmodule
